// File: rtl/bsg_axi4_sched_pkg.sv
// rtl/bsg_axi4_sched_pkg.sv - shared state type and field widths for the AXI4 channel schedulers
package bsg_axi4_sched_pkg;

   localparam int axi_len_width_gp   = 8;
   localparam int axi_size_width_gp  = 3;
   localparam int axi_burst_width_gp = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      AW   = 2'd1,
      W    = 2'd2,
      B    = 2'd3
   } sched_state_e;

   // Slot tag width; a single bit is kept even for two slots so the tag is never empty.
   function automatic int sched_tag_width(input int slot_num);
      return (slot_num <= 2) ? 1 : $clog2(slot_num);
   endfunction

endpackage

// File: rtl/bsg_rr_pick.sv
// rtl/bsg_rr_pick.sv - combinational round-robin pick: first valid slot at or above the pointer, wrapping
module bsg_rr_pick
   import bsg_axi4_sched_pkg::*;
#(
   parameter  int slot_num_p   = 2,
   localparam int tag_width_lp = sched_tag_width(slot_num_p)
)(
   input  logic [slot_num_p-1:0]   valid_i,
   input  logic [tag_width_lp-1:0] ptr_i,
   output logic [tag_width_lp-1:0] winner_o,
   output logic                    any_o
);

   // Walk offsets from farthest to nearest so the nearest valid slot is assigned last and wins.
   always_comb begin
      winner_o = '0;
      for (int k = slot_num_p - 1; k >= 0; k--) begin
         for (int j = 0; j < slot_num_p; j++) begin
            if (valid_i[j] && (((int'(ptr_i) + k) % slot_num_p) == j))
               winner_o = tag_width_lp'(j);
         end
      end
   end

   assign any_o = |valid_i;

endmodule

// File: rtl/axi4_wr_sched.sv
// rtl/axi4_wr_sched.sv - round-robin scheduler sharing one AXI4 write port (AW/W/B) among several slots
module axi4_wr_sched
   import bsg_axi4_sched_pkg::*;
#(
   parameter  int slot_num_p    = 2,
   parameter  int id_width_p    = 6,
   parameter  int addr_width_p  = 64,
   parameter  int data_width_p  = 512,
   localparam int tag_width_lp  = sched_tag_width(slot_num_p),
   localparam int strb_width_lp = data_width_p / 8
)(
   input  logic                                clk_i,
   input  logic                                reset_n_i,

   input  logic [slot_num_p*id_width_p-1:0]    s_awid_i,
   input  logic [slot_num_p*addr_width_p-1:0]  s_awaddr_i,
   input  logic [slot_num_p*8-1:0]             s_awlen_i,
   input  logic [slot_num_p*3-1:0]             s_awsize_i,
   input  logic [slot_num_p*2-1:0]             s_awburst_i,
   input  logic [slot_num_p-1:0]               s_awvalid_i,
   output logic [slot_num_p-1:0]               s_awready_o,
   input  logic [slot_num_p*data_width_p-1:0]  s_wdata_i,
   input  logic [slot_num_p*strb_width_lp-1:0] s_wstrb_i,
   input  logic [slot_num_p-1:0]               s_wlast_i,
   input  logic [slot_num_p-1:0]               s_wvalid_i,
   output logic [slot_num_p-1:0]               s_wready_o,
   output logic [slot_num_p*id_width_p-1:0]    s_bid_o,
   output logic [slot_num_p*2-1:0]             s_bresp_o,
   output logic [slot_num_p-1:0]               s_bvalid_o,
   input  logic [slot_num_p-1:0]               s_bready_i,

   output logic [tag_width_lp+id_width_p-1:0]  m_awid_o,
   output logic [addr_width_p-1:0]             m_awaddr_o,
   output logic [7:0]                          m_awlen_o,
   output logic [2:0]                          m_awsize_o,
   output logic [1:0]                          m_awburst_o,
   output logic                                m_awvalid_o,
   input  logic                                m_awready_i,
   output logic [data_width_p-1:0]             m_wdata_o,
   output logic [strb_width_lp-1:0]            m_wstrb_o,
   output logic                                m_wlast_o,
   output logic                                m_wvalid_o,
   input  logic                                m_wready_i,
   input  logic [tag_width_lp+id_width_p-1:0]  m_bid_i,
   input  logic [1:0]                          m_bresp_i,
   input  logic                                m_bvalid_i,
   output logic                                m_bready_o,

   output logic [tag_width_lp-1:0]             grant_o,
   output logic                                busy_o,
   output logic                                wlast_err_o
);

   sched_state_e                    state_r;
   logic [tag_width_lp-1:0]         rr_ptr_r;
   logic [tag_width_lp-1:0]         grant_r;
   logic [axi_len_width_gp-1:0]     beat_cnt_r;
   logic                            m_awvalid_r;
   logic                            wlast_err_r;

   logic [id_width_p-1:0]           aw_id_r;
   logic [addr_width_p-1:0]         aw_addr_r;
   logic [axi_len_width_gp-1:0]     aw_len_r;
   logic [axi_size_width_gp-1:0]    aw_size_r;
   logic [axi_burst_width_gp-1:0]   aw_burst_r;

   logic [slot_num_p-1:0]           req;
   logic [tag_width_lp-1:0]         pick_idx;
   logic                            pick_any;

   logic [id_width_p-1:0]           win_id;
   logic [addr_width_p-1:0]         win_addr;
   logic [axi_len_width_gp-1:0]     win_len;
   logic [axi_size_width_gp-1:0]    win_size;
   logic [axi_burst_width_gp-1:0]   win_burst;

   logic                            g_wvalid;
   logic                            g_wlast;
   logic                            g_bready;
   logic [data_width_p-1:0]         g_wdata;
   logic [strb_width_lp-1:0]        g_wstrb;

   logic                            last_beat;
   logic                            w_hs;
   logic                            b_hs;
   logic                            bid_tag_unused;

   // Requests are masked while reset is held so no AWREADY can leak out of the reset window.
   assign req = reset_n_i ? s_awvalid_i : '0;

   bsg_rr_pick #(.slot_num_p(slot_num_p)) u_pick (
      .valid_i  (req),
      .ptr_i    (rr_ptr_r),
      .winner_o (pick_idx),
      .any_o    (pick_any)
   );

   always_comb begin
      win_id    = '0;
      win_addr  = '0;
      win_len   = '0;
      win_size  = '0;
      win_burst = '0;
      g_wvalid  = 1'b0;
      g_wlast   = 1'b0;
      g_bready  = 1'b0;
      g_wdata   = '0;
      g_wstrb   = '0;
      for (int i = 0; i < slot_num_p; i++) begin
         if (pick_idx == tag_width_lp'(i)) begin
            win_id    = s_awid_i[i*id_width_p +: id_width_p];
            win_addr  = s_awaddr_i[i*addr_width_p +: addr_width_p];
            win_len   = s_awlen_i[i*8 +: 8];
            win_size  = s_awsize_i[i*3 +: 3];
            win_burst = s_awburst_i[i*2 +: 2];
         end
         if (grant_r == tag_width_lp'(i)) begin
            g_wvalid = s_wvalid_i[i];
            g_wlast  = s_wlast_i[i];
            g_bready = s_bready_i[i];
            g_wdata  = s_wdata_i[i*data_width_p +: data_width_p];
            g_wstrb  = s_wstrb_i[i*strb_width_lp +: strb_width_lp];
         end
      end
   end

   assign last_beat = (beat_cnt_r == '0);
   assign w_hs      = (state_r == W) && g_wvalid && m_wready_i;
   assign b_hs      = (state_r == B) && m_bvalid_i && g_bready;

   always_comb begin
      s_awready_o = '0;
      s_wready_o  = '0;
      s_bvalid_o  = '0;
      s_bid_o     = '0;
      s_bresp_o   = '0;
      for (int i = 0; i < slot_num_p; i++) begin
         if ((state_r == IDLE) && pick_any && (pick_idx == tag_width_lp'(i)))
            s_awready_o[i] = 1'b1;
         if (grant_r == tag_width_lp'(i)) begin
            s_wready_o[i] = (state_r == W) && m_wready_i;
            s_bvalid_o[i] = (state_r == B) && m_bvalid_i;
            if (state_r == B) begin
               s_bid_o[i*id_width_p +: id_width_p] = m_bid_i[id_width_p-1:0];
               s_bresp_o[i*2 +: 2]                 = m_bresp_i;
            end
         end
      end
   end

   // The returning tag is implied by the single burst in flight, so its bits are not consulted.
   assign bid_tag_unused = ^m_bid_i[tag_width_lp+id_width_p-1:id_width_p];

   assign m_awid_o    = {grant_r, aw_id_r};
   assign m_awaddr_o  = aw_addr_r;
   assign m_awlen_o   = aw_len_r;
   assign m_awsize_o  = aw_size_r;
   assign m_awburst_o = aw_burst_r;
   assign m_awvalid_o = m_awvalid_r;

   assign m_wvalid_o  = (state_r == W) && g_wvalid;
   assign m_wdata_o   = g_wdata;
   assign m_wstrb_o   = g_wstrb;
   assign m_wlast_o   = (state_r == W) && last_beat;
   assign m_bready_o  = (state_r == B) && g_bready;

   assign grant_o     = grant_r;
   assign busy_o      = (state_r != IDLE);
   assign wlast_err_o = wlast_err_r;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r     <= IDLE;
         rr_ptr_r    <= '0;
         grant_r     <= '0;
         beat_cnt_r  <= '0;
         m_awvalid_r <= 1'b0;
         wlast_err_r <= 1'b0;
         aw_id_r     <= '0;
         aw_addr_r   <= '0;
         aw_len_r    <= '0;
         aw_size_r   <= '0;
         aw_burst_r  <= '0;
      end else begin
         wlast_err_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (pick_any) begin
                  grant_r     <= pick_idx;
                  aw_id_r     <= win_id;
                  aw_addr_r   <= win_addr;
                  aw_len_r    <= win_len;
                  aw_size_r   <= win_size;
                  aw_burst_r  <= win_burst;
                  m_awvalid_r <= 1'b1;
                  state_r     <= AW;
               end
            end
            AW: begin
               if (m_awready_i) begin
                  m_awvalid_r <= 1'b0;
                  beat_cnt_r  <= aw_len_r;
                  state_r     <= W;
               end
            end
            W: begin
               if (w_hs) begin
                  // A slot's WLAST is only audited; the burst length always comes from AWLEN.
                  wlast_err_r <= (g_wlast != last_beat);
                  if (last_beat)
                     state_r <= B;
                  else
                     beat_cnt_r <= beat_cnt_r - 1'b1;
               end
            end
            B: begin
               if (b_hs) begin
                  rr_ptr_r <= (grant_r == tag_width_lp'(slot_num_p - 1)) ? '0 : grant_r + 1'b1;
                  state_r  <= IDLE;
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi4_wr_sched.sv
// tb/tb_axi4_wr_sched.sv - randomized transaction-level bench for axi4_wr_sched
module tb_axi4_wr_sched;

   localparam int N   = 2;
   localparam int IDW = 6;
   localparam int ADW = 32;
   localparam int DW  = 32;
   localparam int SW  = DW / 8;
   localparam int TW  = 1;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   logic [N*IDW-1:0] s_awid_i;
   logic [N*ADW-1:0] s_awaddr_i;
   logic [N*8-1:0]   s_awlen_i;
   logic [N*3-1:0]   s_awsize_i;
   logic [N*2-1:0]   s_awburst_i;
   logic [N-1:0]     s_awvalid_i, s_awready_o;
   logic [N*DW-1:0]  s_wdata_i;
   logic [N*SW-1:0]  s_wstrb_i;
   logic [N-1:0]     s_wlast_i, s_wvalid_i, s_wready_o;
   logic [N*IDW-1:0] s_bid_o;
   logic [N*2-1:0]   s_bresp_o;
   logic [N-1:0]     s_bvalid_o, s_bready_i;
   logic [TW+IDW-1:0] m_awid_o, m_bid_i;
   logic [ADW-1:0]   m_awaddr_o;
   logic [7:0]       m_awlen_o;
   logic [2:0]       m_awsize_o;
   logic [1:0]       m_awburst_o, m_bresp_i;
   logic             m_awvalid_o, m_awready_i;
   logic [DW-1:0]    m_wdata_o;
   logic [SW-1:0]    m_wstrb_o;
   logic             m_wlast_o, m_wvalid_o, m_wready_i;
   logic             m_bvalid_i, m_bready_o;
   logic [TW-1:0]    grant_o;
   logic             busy_o, wlast_err_o;

   axi4_wr_sched #(
      .slot_num_p(N), .id_width_p(IDW), .addr_width_p(ADW), .data_width_p(DW)
   ) dut (
      .clk_i(clk), .reset_n_i(reset_n),
      .s_awid_i(s_awid_i), .s_awaddr_i(s_awaddr_i), .s_awlen_i(s_awlen_i),
      .s_awsize_i(s_awsize_i), .s_awburst_i(s_awburst_i), .s_awvalid_i(s_awvalid_i),
      .s_awready_o(s_awready_o), .s_wdata_i(s_wdata_i), .s_wstrb_i(s_wstrb_i),
      .s_wlast_i(s_wlast_i), .s_wvalid_i(s_wvalid_i), .s_wready_o(s_wready_o),
      .s_bid_o(s_bid_o), .s_bresp_o(s_bresp_o), .s_bvalid_o(s_bvalid_o), .s_bready_i(s_bready_i),
      .m_awid_o(m_awid_o), .m_awaddr_o(m_awaddr_o), .m_awlen_o(m_awlen_o),
      .m_awsize_o(m_awsize_o), .m_awburst_o(m_awburst_o), .m_awvalid_o(m_awvalid_o),
      .m_awready_i(m_awready_i), .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o),
      .m_wlast_o(m_wlast_o), .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready_i),
      .m_bid_i(m_bid_i), .m_bresp_i(m_bresp_i), .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o),
      .grant_o(grant_o), .busy_o(busy_o), .wlast_err_o(wlast_err_o)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_chk++;
      if (obs !== exp_v) begin
         n_fail++;
         if (n_fail <= 40) $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   // Slot masters: sp 0 = idle/gap, 1 = address offered, 2 = sending data, 3 = awaiting response.
   int             sp[N], gap[N], left[N], len_force[N], beat[N];
   logic           en[N], wv[N], wl[N], br[N];
   logic [IDW-1:0] a_id[N];
   logic [ADW-1:0] a_addr[N];
   logic [7:0]     a_len[N];
   logic [2:0]     a_size[N];
   logic [1:0]     a_burst[N];
   logic [DW-1:0]  wd[N];
   logic [SW-1:0]  ws[N];
   logic           eager;
   int             err_pct, gcount, cyc;

   // Downstream slave
   logic              bv, b_sched;
   int                bdelay;
   logic [TW+IDW-1:0] bid;
   logic [1:0]        bresp;

   // Reference: one burst in flight; phase 1 = master address, 2 = data, 3 = response.
   logic              mb, err_due;
   int                mstep, mg, mptr, mbeats, mlen, done_cnt;
   logic [TW+IDW-1:0] m_eid;
   logic [44:0]       m_efields;

   function automatic int rr_first(input logic [N-1:0] r, input int ptr);
      for (int k = 0; k < N; k++)
         if (r[(ptr + k) % N]) return (ptr + k) % N;
      return 0;
   endfunction

   task automatic drive();
      for (int s = 0; s < N; s++) begin
         if (sp[s] == 0 && en[s] && left[s] > 0) begin
            if (gap[s] > 0) gap[s]--;
            else begin
               a_id[s]   = IDW'($urandom);
               a_addr[s] = $urandom;
               if (len_force[s] >= 0) a_len[s] = 8'(len_force[s]);
               else begin
                  if (gcount == 0) a_len[s] = 8'd0;
                  else if (gcount == 1) a_len[s] = 8'd255;
                  else if ($urandom_range(0, 19) == 0) a_len[s] = 8'($urandom_range(0, 255));
                  else a_len[s] = 8'($urandom_range(0, 6));
                  gcount++;
               end
               a_size[s]  = 3'($urandom_range(0, 2));
               a_burst[s] = 2'($urandom_range(0, 2));
               sp[s] = 1;
               beat[s] = 0;
            end
         end
         if (sp[s] == 2 && !wv[s] && (eager || $urandom_range(0, 3) != 0)) begin
            wv[s] = 1'b1;
            wd[s] = $urandom;
            ws[s] = SW'($urandom);
            wl[s] = (beat[s] == int'(a_len[s]));
            if ($urandom_range(0, 99) < err_pct) wl[s] = ~wl[s];
         end
         br[s] = eager || ($urandom_range(0, 2) != 0);
         s_awvalid_i[s]              = (sp[s] == 1);
         s_awid_i[s*IDW +: IDW]      = a_id[s];
         s_awaddr_i[s*ADW +: ADW]    = a_addr[s];
         s_awlen_i[s*8 +: 8]         = a_len[s];
         s_awsize_i[s*3 +: 3]        = a_size[s];
         s_awburst_i[s*2 +: 2]       = a_burst[s];
         if (sp[s] == 2) begin
            s_wvalid_i[s] = wv[s];
            s_wlast_i[s]  = wl[s];
            s_wdata_i[s*DW +: DW] = wd[s];
            s_wstrb_i[s*SW +: SW] = ws[s];
         end else begin
            // Idle or waiting slots present stray W traffic that must never reach the master.
            s_wvalid_i[s] = (sp[s] == 1) && ($urandom_range(0, 1) == 1);
            s_wlast_i[s]  = 1'($urandom);
            s_wdata_i[s*DW +: DW] = $urandom;
            s_wstrb_i[s*SW +: SW] = SW'($urandom);
         end
         s_bready_i[s] = br[s];
      end
      m_awready_i = eager || ($urandom_range(0, 2) == 0);
      m_wready_i  = eager || ($urandom_range(0, 1) == 1);
      if (b_sched && !bv) begin
         if (bdelay > 0) bdelay--;
         else begin
            bv    = 1'b1;
            bid   = (TW+IDW)'($urandom);
            bresp = 2'($urandom);
         end
      end
      m_bvalid_i = bv;
      m_bid_i    = bid;
      m_bresp_i  = bresp;
   endtask

   task automatic observe();
      logic [N-1:0] req, exp_v;
      int w;
      logic nerr;
      nerr = 1'b0;
      for (int s = 0; s < N; s++) req[s] = (sp[s] == 1);
      w = rr_first(req, mptr);

      check_eq("busy", busy_o, mb);
      check_eq("wlast_err", wlast_err_o, err_due);
      exp_v = '0;
      if (!mb && req != '0) exp_v[w] = 1'b1;
      check_eq("s_awready", s_awready_o, exp_v);
      check_eq("m_awvalid", m_awvalid_o, mb && mstep == 1);
      if (mb) check_eq("grant", grant_o, mg);
      if (mb && mstep == 1) begin
         check_eq("m_awid", m_awid_o, m_eid);
         check_eq("m_aw_fields", {m_awaddr_o, m_awlen_o, m_awsize_o, m_awburst_o}, m_efields);
      end
      exp_v = '0;
      if (mb && mstep == 2) exp_v[mg] = m_wready_i;
      check_eq("s_wready", s_wready_o, exp_v);
      check_eq("m_wvalid", m_wvalid_o, mb && mstep == 2 && wv[mg]);
      if (mb && mstep == 2 && wv[mg]) begin
         check_eq("m_wdata", m_wdata_o, wd[mg]);
         check_eq("m_wstrb", m_wstrb_o, ws[mg]);
         check_eq("m_wlast", m_wlast_o, mbeats == mlen);
      end
      check_eq("m_bready", m_bready_o, mb && mstep == 3 && br[mg]);
      exp_v = '0;
      if (mb && mstep == 3) exp_v[mg] = m_bvalid_i;
      check_eq("s_bvalid", s_bvalid_o, exp_v);
      if (mb && mstep == 3 && m_bvalid_i) begin
         check_eq("s_bid", s_bid_o[mg*IDW +: IDW], m_bid_i[IDW-1:0]);
         check_eq("s_bresp", s_bresp_o[mg*2 +: 2], m_bresp_i);
      end

      if (!mb && req != '0) begin
         mb = 1'b1; mg = w; mstep = 1; mlen = int'(a_len[w]);
         m_eid = {TW'(w), a_id[w]};
         m_efields = {a_addr[w], a_len[w], a_size[w], a_burst[w]};
         sp[w] = 2;
      end else if (mb && mstep == 1 && m_awready_i) begin
         mstep = 2; mbeats = 0;
      end else if (mb && mstep == 2 && wv[mg] && m_wready_i) begin
         nerr = (wl[mg] != (mbeats == mlen));
         wv[mg] = 1'b0;
         beat[mg]++;
         if (mbeats == mlen) begin
            mstep = 3; sp[mg] = 3; b_sched = 1'b1; bdelay = $urandom_range(0, 12);
         end else mbeats++;
      end else if (mb && mstep == 3 && m_bvalid_i && br[mg]) begin
         mb = 1'b0; mptr = (mg + 1) % N; sp[mg] = 0; left[mg]--;
         gap[mg] = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 4);
         done_cnt++; bv = 1'b0; b_sched = 1'b0;
      end
      err_due = nerr;
   endtask

   task automatic step();
      @(negedge clk);
      drive();
      #1;
      observe();
      cyc++;
   endtask

   task automatic clear_state();
      for (int s = 0; s < N; s++) begin
         sp[s] = 0; gap[s] = 0; left[s] = 0; len_force[s] = -1; beat[s] = 0;
         en[s] = 1'b0; wv[s] = 1'b0; wl[s] = 1'b0; br[s] = 1'b0;
      end
      bv = 1'b0; b_sched = 1'b0; bdelay = 0;
      mb = 1'b0; err_due = 1'b0; mstep = 0; mptr = 0; mbeats = 0; mlen = 0;
   endtask

   initial begin
      int base;
      reset_n = 1'b0;
      bid = '0; bresp = '0; eager = 1'b0; err_pct = 0; gcount = 0; done_cnt = 0; cyc = 0;
      clear_state();
      @(negedge clk);
      drive();
      s_awvalid_i = '1;
      #1;
      check_eq("rst_s_awready", s_awready_o, 0);
      check_eq("rst_busy", busy_o, 0);
      check_eq("rst_m_awvalid", m_awvalid_o, 0);
      check_eq("rst_grant", grant_o, 0);
      check_eq("rst_wlast_err", wlast_err_o, 0);
      check_eq("rst_m_awid", m_awid_o, 0);
      check_eq("rst_m_awaddr", m_awaddr_o, 0);
      @(negedge clk);
      s_awvalid_i = '0;
      reset_n = 1'b1;

      // Single slot 1, awlen=3, ready always high.
      eager = 1'b1; en[1] = 1'b1; left[1] = 1; len_force[1] = 3;
      cyc = 0;
      while (done_cnt < 1 && cyc < 200) step();
      check_eq("single_burst_done", done_cnt, 1);

      // Both slots, random gaps, backpressure, occasional WLAST errors, awlen 0 and 255.
      eager = 1'b0; err_pct = 8;
      for (int s = 0; s < N; s++) begin
         en[s] = 1'b1; left[s] = 20; len_force[s] = -1;
      end
      cyc = 0;
      while (done_cnt < 41 && cyc < 30000) step();
      check_eq("random_bursts_done", done_cnt, 41);

      // Reset in the middle of a W burst.
      err_pct = 0; en[0] = 1'b0; en[1] = 1'b1; left[1] = 1; len_force[1] = 7;
      cyc = 0;
      while (!(mb && mstep == 2 && mbeats >= 2) && cyc < 300) step();
      check_eq("reached_mid_w", mb && mstep == 2 && mbeats >= 2, 1);
      @(negedge clk);
      s_awvalid_i[0] = 1'b1;
      s_wvalid_i[1]  = 1'b1;
      reset_n = 1'b0;
      #1;
      check_eq("arst_s_awready", s_awready_o, 0);
      check_eq("arst_s_wready", s_wready_o, 0);
      check_eq("arst_s_bvalid", s_bvalid_o, 0);
      check_eq("arst_m_awvalid", m_awvalid_o, 0);
      check_eq("arst_m_wvalid", m_wvalid_o, 0);
      check_eq("arst_m_bready", m_bready_o, 0);
      check_eq("arst_busy", busy_o, 0);
      clear_state();
      @(negedge clk);
      s_awvalid_i = '0;
      s_wvalid_i  = '0;
      reset_n = 1'b1;

      for (int s = 0; s < N; s++) begin
         en[s] = 1'b1; left[s] = 1; len_force[s] = 1;
      end
      base = done_cnt;
      step();
      check_eq("post_reset_priority", s_awready_o, 2'b01);
      cyc = 0;
      while (done_cnt < base + 2 && cyc < 400) step();
      check_eq("post_reset_done", done_cnt, base + 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/axi4_wr_sched.md
Name: axi4_wr_sched

Overview:
- Round-robin write-channel scheduler that shares one AXI4 master write port (AW/W/B) among slot_num_p slave-side requesters.
- Sits between accelerator write masters and the single upstream AXI4 master port, in place of a full crossbar when only the write path needs sharing.
- One write burst is in flight at a time. The W beats are locked to the AW grant, and the B response is routed back to the granted slot.
- Slot index is prepended to the outgoing AWID and stripped from the returning BID.

Parameters:
- slot_num_p, 2, number of requesting slots (>=2).
- id_width_p, 6, per-slot AXI ID width.
- addr_width_p, 64, AXI address width.
- data_width_p, 512, AXI data width.
- tag_width_lp (local), max(1, clog2(slot_num_p)), slot tag width prepended to the ID.

Ports:
Flattened per-slot buses: slot i occupies bits [i*w +: w].
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- s_awid_i  in  slot_num_p*id_width_p  per-slot AWID.
- s_awaddr_i  in  slot_num_p*addr_width_p  per-slot AWADDR.
- s_awlen_i  in  slot_num_p*8  per-slot AWLEN.
- s_awsize_i  in  slot_num_p*3  per-slot AWSIZE.
- s_awburst_i  in  slot_num_p*2  per-slot AWBURST.
- s_awvalid_i  in  slot_num_p  per-slot AWVALID.
- s_awready_o  out  slot_num_p  per-slot AWREADY.
- s_wdata_i  in  slot_num_p*data_width_p  per-slot WDATA.
- s_wstrb_i  in  slot_num_p*data_width_p/8  per-slot WSTRB.
- s_wlast_i  in  slot_num_p  per-slot WLAST.
- s_wvalid_i  in  slot_num_p  per-slot WVALID.
- s_wready_o  out  slot_num_p  per-slot WREADY.
- s_bid_o  out  slot_num_p*id_width_p  per-slot BID.
- s_bresp_o  out  slot_num_p*2  per-slot BRESP.
- s_bvalid_o  out  slot_num_p  per-slot BVALID.
- s_bready_i  in  slot_num_p  per-slot BREADY.
- m_awid_o  out  tag_width_lp+id_width_p  {slot tag, AWID}.
- m_awaddr_o  out  addr_width_p  master AWADDR.
- m_awlen_o  out  8  master AWLEN.
- m_awsize_o  out  3  master AWSIZE.
- m_awburst_o  out  2  master AWBURST.
- m_awvalid_o  out  1  master AWVALID.
- m_awready_i  in  1  master AWREADY.
- m_wdata_o  out  data_width_p  master WDATA.
- m_wstrb_o  out  data_width_p/8  master WSTRB.
- m_wlast_o  out  1  master WLAST.
- m_wvalid_o  out  1  master WVALID.
- m_wready_i  in  1  master WREADY.
- m_bid_i  in  tag_width_lp+id_width_p  master BID.
- m_bresp_i  in  2  master BRESP.
- m_bvalid_i  in  1  master BVALID.
- m_bready_o  out  1  master BREADY.
- grant_o  out  tag_width_lp  currently granted slot.
- busy_o  out  1  high in any state other than IDLE.
- wlast_err_o  out  1  one-cycle registered pulse on a WLAST mismatch.

Behaviour:
- Reset: asynchronous on reset_n_i low, regardless of state.
  - state=IDLE, rr pointer=0, grant=0, beat counter=0, AW holding registers=0.
  - All valid/ready outputs=0, wlast_err_o=0, busy_o=0.
  - Reset mid-burst abandons the burst; no recovery is attempted.
- FSM states: IDLE, AW, W, B.
- IDLE:
  - Winner = first slot with s_awvalid set, searching from rr pointer upward and wrapping at slot_num_p.
  - s_awready_o[winner]=1 in the same cycle (combinational). The winner's AW fields are captured into holding registers; grant <= winner; next state AW.
  - No s_awvalid set: remain in IDLE, all s_awready=0.
- AW:
  - m_awvalid_o=1; m_aw* driven from the holding registers; m_awid_o={grant, captured id}.
  - m_awvalid_o stays stable until m_awready_i.
  - On handshake: beat counter <= captured awlen; next state W.
  - First m_awvalid_o occurs 1 cycle after the s_aw handshake.
- W:
  - Combinational pass-through from the granted slot only: m_wvalid_o=s_wvalid[grant], s_wready[grant]=m_wready_i, m_wdata/m_wstrb from the granted slot.
  - m_wlast_o is generated internally: high when counter==0, never taken from s_wlast.
  - Each handshake with counter>0 decrements the counter.
  - Handshake with counter==0: next state B.
  - On any handshake where s_wlast[grant] != (counter==0): wlast_err_o pulses on the next cycle and the burst continues.
  - awlen=0 is a single beat; awlen=255 is 256 beats; the counter never wraps.
- B:
  - m_bready_o=s_bready[grant], s_bvalid[grant]=m_bvalid_i.
  - s_bid[grant]=m_bid_i[id_width_p-1:0]; the BID tag bits are ignored. s_bresp[grant]=m_bresp_i.
  - On handshake: rr pointer <= grant+1 (wraps to 0 at slot_num_p); next state IDLE.
- Ungranted slots: s_awready, s_wready and s_bvalid are always 0; their W data is ignored.
- Simultaneous new s_awvalid during W/B: held off until the return to IDLE, at least 1 idle cycle between bursts.
- AXI compliance: valid outputs never drop without a handshake, except on reset.

Decomposition:
- Shared package bsg_axi4_sched_pkg: state enum (IDLE, AW, W, B), the tag-width function, and the AXI len/size/burst widths.
- Sub-module bsg_rr_pick (combinational round-robin first-one-from-pointer, slot_num_p wide).
  - Outputs: winner index and any-valid.
  - Reused later by a read-channel scheduler.

Test Plan:
- Single slot 1, awlen=3, m_awready/m_wready always 1:
  - s_awready[1] in cycle 0, m_awvalid in cycle 1, m_awid={1,id}.
  - Exactly 4 W beats with m_wlast on beat 4; BID returned to slot 1 with the tag stripped.
- Both slots assert awvalid continuously, 6 bursts:
  - Grant sequence 0,1,0,1,0,1; grant_o matches; no beats leak to the ungranted slot.
- Backpressure: m_awready low for 5 cycles, m_wready toggling, m_bvalid delayed 10 cycles:
  - m_aw* stable while waiting; beat count correct; s_bvalid only on the granted slot.
- Slot drives s_wlast on beat 2 of an awlen=3 burst:
  - wlast_err_o pulses 1 cycle after beat 2; m_wlast still only on beat 4; FSM returns to IDLE.
- awlen=0 and awlen=255 bursts:
  - 1 and 256 beats respectively, with m_wlast on the final beat only.
- reset_n_i asserted mid-W:
  - All valid/ready outputs 0 immediately (asynchronously); busy_o=0; after release, slot 0 has priority.
